instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch front end for the SCC core: holds the program counter, reads 32-bit words from a synchronous instruction memory, buffers them in a small prefetch queue, and presents them to the core over a valid/ready handshake. It is the supplier of the `instruction` stream the core consumes. A redirect input (branch/jump) flushes the queue and restarts fetch at a new address.

## Interface
- `ADDR_WIDTH`, 8, word-address width of instruction memory and PC.
- `DEPTH`, 4, prefetch queue entries (power of two, ≥2).
- `RESET_PC`, 0, PC loaded on reset.

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `imem_rd_en`  out  1  memory read strobe.
- `imem_addr`  out  ADDR_WIDTH  word address of read.
- `imem_rdata`  in  32  read data, valid exactly one cycle after `imem_rd_en`.
- `instruction`  out  32  instruction at queue head.
- `instr_pc`  out  ADDR_WIDTH  word address of `instruction`.
- `instr_valid`  out  1  queue non-empty.
- `instr_ready`  in  1  core accepts head this cycle.
- `redirect_valid`  in  1  restart fetch.
- `redirect_pc`  in  ADDR_WIDTH  new fetch address.
- `fetch_count`  out  32  accepted instructions (only with `IFU_PERF_CNT_EN`).
- `stall_count`  out  32  backpressure cycles (only with `IFU_PERF_CNT_EN`).

## Operation
- State: `fetch_pc`, queue (`DEPTH` × {32-bit instr, pc}), `count`, one in-flight flag `inflight` + `inflight_pc`, `kill` flag.
- Issue: `imem_rd_en`=1 when not `reset`, not `redirect_valid`, and `count + inflight < DEPTH` (no same-cycle pop credit). `imem_addr`=`fetch_pc`; `fetch_pc` increments by 1, wrapping mod 2^ADDR_WIDTH.
- Return: cycle after issue, `imem_rdata` pushed with `inflight_pc` unless `kill` set; killed data discarded.
- Handshake: transfer when `instr_valid && instr_ready`; head popped. While `instr_valid && !instr_ready`, `instruction`/`instr_pc` held stable. Push and pop in same cycle allowed; `count` unchanged.
- Redirect (sampled at edge): queue cleared (`count`=0), any in-flight read marked killed, `fetch_pc`←`redirect_pc`, no issue that cycle. A transfer coinciding with `redirect_valid` still counts as completed. `redirect_valid` with `reset`: reset wins.
- Overflow impossible by credit rule; pop from empty ignored (`instr_ready` with `instr_valid`=0 is no-op).
- Reset values: `fetch_pc`=`RESET_PC`, `count`=0, `inflight`=0, `kill`=0; outputs `imem_rd_en`=0, `imem_addr`=`RESET_PC`, `instr_valid`=0, `instruction`=0, `instr_pc`=0, counters=0. Reset mid-operation discards queue and in-flight read.

## Timing
- After reset deasserts at edge E0: first issue during cycle E0–E1, data pushed at E2, `instr_valid`=1 after E2.
- Redirect at edge R: `instr_valid`=0 after R; issue at `redirect_pc` in cycle R–R+1; first redirected instruction valid after R+2.
- Sustained throughput 1 instruction/cycle with `instr_ready` held high (DEPTH ≥ 2).
- Outputs registered except `imem_rd_en`/`imem_addr` (combinational from state and `redirect_valid`).

## Configuration
- `IFU_PERF_CNT_EN` defined: `fetch_count` increments on each transfer, `stall_count` on each cycle with `instr_valid && !instr_ready`; both wrap at 2^32, cleared by reset, not cleared by redirect.
- Undefined: counter registers and both ports absent; all other behaviour identical.

## Test plan
- Reset, `instr_ready`=1, mem[i]=0x1000_0000+i: `instr_valid` high after 2nd edge; pcs 0,1,2,… with instructions 0x1000_0000,0x1000_0001,… one per cycle, no gaps.
- Hold `instr_ready`=0 for 10 cycles: exactly `DEPTH`=4 entries buffered, `imem_rd_en` low once full, head stable; release → pcs continue in order, none lost or duplicated.
- With queue full, pulse `redirect_valid`, `redirect_pc`=0x40: `instr_valid` low next cycle, next delivered pc 0x40 (0x1000_0040) after 2 edges, no stale or killed word delivered.
- `RESET_PC`=0xFE, `ADDR_WIDTH`=8: delivered pcs 0xFE, 0xFF, 0x00, 0x01.
- Assert `reset` mid-stream with items queued: next cycle `instr_valid`=0, restart at `RESET_PC`; reset+redirect same cycle → restart at `RESET_PC`.
- `IFU_PERF_CNT_EN`: 20 transfers with 5 stall cycles → `fetch_count`=20, `stall_count`=5.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, synchronous imem reads, prefetch queue, valid/ready delivery.
// Optional performance counters (fetch_count/stall_count) are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_rd_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_rdata,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic                  inflight_q, inflight_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;

  logic [31:0]           instr_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q    [DEPTH];

  logic issue;
  logic push;
  logic pop;

  // Issue is blocked in a redirect cycle, so the only read that can be in flight at a
  // redirect edge is the one returning right now; clearing the queue on that edge kills it.
  always_comb begin
    issue = !reset && !redirect_valid &&
            ((count_q + CW'(inflight_q)) < CW'(DEPTH));
    push  = inflight_q && !redirect_valid;
    pop   = (count_q != '0) && instr_ready;
  end

  assign imem_rd_en  = issue;
  assign imem_addr   = reset ? RESET_PC : fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instruction = instr_valid ? instr_mem_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q]    : '0;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = issue ? fetch_pc_q : inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      if (push)  wr_ptr_d   = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d   = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // NOTE: queue storage is not reset; count_q gates visibility and the outputs mask stale words.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem_q[wr_ptr_q] <= imem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count_q;
  logic [31:0] stall_count_q;

  // Redirects do not clear these; a transfer in a redirect cycle still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      if (pop)                         fetch_count_q <= fetch_count_q + 32'd1;
      if (instr_valid && !instr_ready) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, redirect, reset, PC wrap, counters.
// Define IFU_PERF_CNT_EN for the whole compile to exercise the performance counters.
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        instr_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;

  logic        imem_rd_en,  imem_rd_en_b;
  logic [7:0]  imem_addr,   imem_addr_b;
  logic [31:0] imem_rdata,  imem_rdata_b;
  logic [31:0] instruction, instruction_b;
  logic [7:0]  instr_pc,    instr_pc_b;
  logic        instr_valid, instr_valid_b;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count, fetch_count_b, stall_count_b;
`endif

  int vectors = 0;
  int miscompares = 0;

  instr_fetch_unit #(.ADDR_WIDTH(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instruction    (instruction),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  // Second instance starts near the top of the address space to show PC wrap.
  instr_fetch_unit #(.ADDR_WIDTH(8), .DEPTH(4), .RESET_PC(8'hFE)) dut_wrap (
    .clk            (clk),
    .reset          (reset),
    .imem_rd_en     (imem_rd_en_b),
    .imem_addr      (imem_addr_b),
    .imem_rdata     (imem_rdata_b),
    .instruction    (instruction_b),
    .instr_pc       (instr_pc_b),
    .instr_valid    (instr_valid_b),
    .instr_ready    (1'b1),
    .redirect_valid (1'b0),
    .redirect_pc    (8'h00)
`ifdef IFU_PERF_CNT_EN
    ,
    .fetch_count    (fetch_count_b),
    .stall_count    (stall_count_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memories holding mem[i] = 0x1000_0000 + i.
  always @(posedge clk) begin
    if (imem_rd_en)   imem_rdata   <= 32'h1000_0000 + 32'(imem_addr);
    if (imem_rd_en_b) imem_rdata_b <= 32'h1000_0000 + 32'(imem_addr_b);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [7:0] pc);
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
    check({tag, "_pc"},    32'(instr_pc),    32'(pc));
    check({tag, "_instr"}, instruction,      32'h1000_0000 + 32'(pc));
  endtask

  initial begin
    logic [7:0] wrap_pc;
    reset          = 1'b1;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;

    // Reset state.
    step(2);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instruction,      32'd0);
    check("rst_pc",    32'(instr_pc),    32'd0);
    check("rst_rd_en", 32'(imem_rd_en),  32'd0);
    check("rst_addr",  32'(imem_addr),   32'd0);
    check("rst_addr_wrap", 32'(imem_addr_b), 32'hFE);

    // First issue in the cycle after reset drops; data visible after the second edge.
    reset = 1'b0;
    #1;
    check("e0_rd_en", 32'(imem_rd_en), 32'd1);
    check("e0_addr",  32'(imem_addr),  32'd0);
    step(1);
    check("e1_valid", 32'(instr_valid), 32'd0);
    check("e1_addr",  32'(imem_addr),   32'd1);
    step(1);

    // One instruction per cycle, no gaps; wrap instance goes FE, FF, 00, 01.
    for (int j = 0; j < 7; j++) begin
      if (j > 0) step(1);
      check_head("stream", 8'(j));
      if (j < 4) begin
        wrap_pc = 8'hFE + 8'(j);
        check("wrap_pc",    32'(instr_pc_b), 32'(wrap_pc));
        check("wrap_instr", instruction_b,   32'h1000_0000 + 32'(wrap_pc));
      end
    end

    // Backpressure: head pc 6 held, queue fills to 4 and issue stops.
    instr_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check_head("stall", 8'd6);
      check("stall_rd_en", 32'(imem_rd_en), (k == 1) ? 32'd1 : 32'd0);
    end
    check("full_addr", 32'(imem_addr), 32'd10);

    // Release: no issue in the release cycle (no pop credit), then in-order delivery.
    instr_ready = 1'b1;
    #1;
    check("release_rd_en", 32'(imem_rd_en), 32'd0);
    for (int j = 1; j <= 6; j++) begin
      step(1);
      check_head("release", 8'(6 + j));
    end

    // Refill to full, then redirect to 0x40.
    instr_ready = 1'b0;
    step(2);
    check_head("refill", 8'd12);
    check("refill_rd_en", 32'(imem_rd_en), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h40;
    #1;
    check("redir_rd_en", 32'(imem_rd_en), 32'd0);
    step(1);
    redirect_valid = 1'b0;
    #1;
    check("redir_valid0", 32'(instr_valid), 32'd0);
    check("redir_rd_en1", 32'(imem_rd_en),  32'd1);
    check("redir_addr",   32'(imem_addr),   32'h40);
    instr_ready = 1'b1;
    step(1);
    check("redir_valid1", 32'(instr_valid), 32'd0);
    step(1);
    check_head("redir0", 8'h40);
    step(1);
    check_head("redir1", 8'h41);
    step(1);
    check_head("redir2", 8'h42);

    // Reset mid-stream together with a redirect: reset wins.
    instr_ready = 1'b0;
    step(2);
    check_head("pre_rst", 8'h42);
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    #1;
    check("rst_redir_rd_en", 32'(imem_rd_en), 32'd0);
    step(1);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_instr", instruction,      32'd0);
    check("mid_rst_pc",    32'(instr_pc),    32'd0);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b1;
    #1;
    check("restart_rd_en", 32'(imem_rd_en), 32'd1);
    check("restart_addr",  32'(imem_addr),  32'd0);
    step(2);
    check_head("restart", 8'd0);

    // 10 transfers, 5 stall cycles, 10 transfers.
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check_head("perf_a", 8'(k));
    end
    instr_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      check_head("perf_stall", 8'd10);
    end
    instr_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      check_head("perf_b", 8'(10 + k));
    end
`ifdef IFU_PERF_CNT_EN
    check("fetch_count", fetch_count, 32'd20);
    check("stall_count", stall_count, 32'd5);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
